// File: rtl/hex_scroll_pkg.sv
// hex_scroll_pkg: shared mode codes, blank pattern and segment type for the HEX scroll driver.
package hex_scroll_pkg;
    typedef logic [7:0] seg_t;
    localparam logic [1:0] MODE_STATIC   = 2'b00;
    localparam logic [1:0] MODE_SCROLL_L = 2'b01;
    localparam logic [1:0] MODE_SCROLL_R = 2'b10;
    localparam logic [1:0] MODE_BLINK    = 2'b11;
    localparam seg_t SEG_BLANK = 8'hFF;
endpackage

// File: rtl/hex_tick_gen.sv
// hex_tick_gen: prescaled base tick and a step every (rotation+1) base ticks.
module hex_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rotation,
    output logic       base_tick,
    output logic       step
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0] presc;
    logic [2:0]    step_cnt;
    assign base_tick = presc == PW'(TICK_DIV - 1);
    // A counter already past a lowered rotation runs on to its natural wrap at 7.
    assign step = base_tick && step_cnt == rotation;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            step_cnt <= '0;
        end else begin
            presc <= base_tick ? '0 : presc + 1'b1;
            if (base_tick)
                step_cnt <= step ? '0 : step_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hex_scroll_driver.sv
// hex_scroll_driver: double-buffered 8-digit seven-segment driver with static, scroll and blink modes.
// Optional HEX_DP_HEARTBEAT_EN drives the hex0 decimal point from a base-tick heartbeat flop.
module hex_scroll_driver
    import hex_scroll_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BUF_DEPTH  = 16,
    parameter int TICK_DIV   = 12500000,
    parameter int SEG_W      = 8
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_reset,
    input  logic                         wr_en,
    input  logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
    input  logic [SEG_W-1:0]             wr_data,
    input  logic                         len_we,
    input  logic [$clog2(BUF_DEPTH):0]   len_data,
    input  logic                         commit,
    input  logic [1:0]                   modes,
    input  logic [2:0]                   rotation,
    output logic                         busy,
    output logic                         step_pulse,
    output logic [SEG_W-1:0]             hex0,
    output logic [SEG_W-1:0]             hex1,
    output logic [SEG_W-1:0]             hex2,
    output logic [SEG_W-1:0]             hex3,
    output logic [SEG_W-1:0]             hex4,
    output logic [SEG_W-1:0]             hex5,
    output logic [SEG_W-1:0]             hex6,
    output logic [SEG_W-1:0]             hex7
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int LW = AW + 1;
    seg_t          shadow [BUF_DEPTH];
    seg_t          active [BUF_DEPTH];
    seg_t          hex_d  [NUM_DIGITS];
    seg_t          hex_q  [NUM_DIGITS];
    logic [LW-1:0] shadow_len, active_len, offset;
    logic          blink_phase, step, blank;
`ifdef HEX_DP_HEARTBEAT_EN
    logic          base_tick, heartbeat;
`endif
    hex_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (CLOCK_50),
        .rst      (reset_reset),
        .rotation (rotation),
`ifdef HEX_DP_HEARTBEAT_EN
        .base_tick(base_tick),
`else
        .base_tick(),
`endif
        .step     (step)
    );
    assign step_pulse = step;
    assign blank = active_len == '0 || (modes == MODE_BLINK && blink_phase);
    // Position g = 0 is hex7; offset and g are both below active_len, so one subtract wraps.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        logic [LW-1:0] sum, idx;
        assign sum = offset + LW'(g);
        assign idx = (sum >= active_len) ? sum - active_len : sum;
        assign hex_d[g] = (blank || LW'(g) >= active_len) ? SEG_BLANK : active[idx[AW-1:0]];
    end
    always_ff @(posedge CLOCK_50 or posedge reset_reset) begin
        if (reset_reset) begin
            shadow      <= '{default: SEG_BLANK};
            active      <= '{default: SEG_BLANK};
            hex_q       <= '{default: SEG_BLANK};
            shadow_len  <= '0;
            active_len  <= '0;
            offset      <= '0;
            blink_phase <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (wr_en)
                shadow[wr_addr] <= wr_data;
            if (len_we)
                shadow_len <= (len_data > LW'(BUF_DEPTH)) ? LW'(BUF_DEPTH) : len_data;
            hex_q <= hex_d;
            if (step && busy) begin
                active      <= shadow;
                active_len  <= shadow_len;
                offset      <= '0;
                blink_phase <= 1'b0;
                busy        <= 1'b0;
            end else begin
                if (commit)
                    busy <= 1'b1;
                if (step) begin
                    blink_phase <= (modes == MODE_BLINK) ? ~blink_phase : 1'b0;
                    if (active_len > LW'(1))
                        offset <= (modes == MODE_SCROLL_L) ? ((offset == active_len - 1'b1) ? '0 : offset + 1'b1) :
                                  (modes == MODE_SCROLL_R) ? ((offset == '0) ? active_len - 1'b1 : offset - 1'b1) :
                                  offset;
                end
            end
        end
    end
`ifdef HEX_DP_HEARTBEAT_EN
    always_ff @(posedge CLOCK_50 or posedge reset_reset) begin
        if (reset_reset)
            heartbeat <= 1'b1;
        else if (base_tick)
            heartbeat <= ~heartbeat;
    end
    assign hex0 = {heartbeat, hex_q[7][6:0]};
`else
    assign hex0 = hex_q[7];
`endif
    assign hex1 = hex_q[6];
    assign hex2 = hex_q[5];
    assign hex3 = hex_q[4];
    assign hex4 = hex_q[3];
    assign hex5 = hex_q[2];
    assign hex6 = hex_q[1];
    assign hex7 = hex_q[0];
endmodule

// File: tb/tb_hex_scroll_driver.sv
// tb_hex_scroll_driver: directed checks of load, scroll, blink, commit timing, clamp and async reset.
module tb_hex_scroll_driver;
    logic        clk = 1'b0, rst, wr_en, len_we, commit, busy, step_pulse;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  len_data;
    logic [1:0]  modes;
    logic [2:0]  rotation;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [63:0] bus;
    int          compared = 0, mismatched = 0;
`ifdef HEX_DP_HEARTBEAT_EN
    localparam logic [63:0] DPM = ~64'h80;
`else
    localparam logic [63:0] DPM = '1;
`endif
    localparam logic [63:0] ALL_FF = '1;
    localparam logic [63:0] P0 = 64'hC0F9A4B0999282F8;
    hex_scroll_driver #(.TICK_DIV(4)) dut (
        .CLOCK_50(clk), .reset_reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_we(len_we), .len_data(len_data), .commit(commit), .modes(modes), .rotation(rotation),
        .busy(busy), .step_pulse(step_pulse),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
    );
    assign bus = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_hex(input string tag, input logic [63:0] exp);
        chk(tag, bus & DPM, exp & DPM);
    endtask
    task automatic wait_step(output int n);
        n = 0;
        while (!step_pulse && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!step_pulse) begin
            compared++;
            mismatched++;
            $error("FAIL step_wait: observed no step_pulse expected one within 200 cycles");
        end
    endtask
    task automatic do_step;
        int n;
        wait_step(n);
        @(negedge clk);
        @(negedge clk);
    endtask
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        len_we = 1'b0;
    endtask
    task automatic pulse_commit;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask
    initial begin
        logic [7:0] pat [8];
        int n;
        logic h;
        pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        rst = 1'b1; wr_en = 0; len_we = 0; commit = 0; wr_addr = 0; wr_data = 0;
        len_data = 0; modes = 2'b00; rotation = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_step_pulse", step_pulse, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_hex("reset_hex", ALL_FF);
        chk("reset_busy", busy, 0);
        // static load, length written alongside the first entry
        len_we = 1'b1;
        len_data = 5'd8;
        for (int i = 0; i < 8; i++) wr(4'(i), pat[i]);
        pulse_commit();
        chk("commit_busy", busy, 1);
        wait_step(n);
        @(negedge clk);
        chk("apply_busy_clear", busy, 0);
        chk_hex("hex_latency", ALL_FF);
        @(negedge clk);
        chk_hex("static_load", P0);
        for (int i = 0; i < 5; i++) begin
            do_step();
            chk_hex("static_hold", P0);
        end
        // scroll left, rotation 1: 8-cycle step period
        modes = 2'b01;
        rotation = 3'd1;
        do_step();
        chk_hex("scroll_l_1", 64'hF9A4B0999282F8C0);
        wait_step(n);
        chk("step_period", 32'(n), 32'd6);
        @(negedge clk);
        @(negedge clk);
        chk_hex("scroll_l_2", 64'hA4B0999282F8C0F9);
        repeat (6) do_step();
        chk_hex("scroll_l_wrap", P0);
        // scroll right, length 3
        rotation = 3'd0;
        modes = 2'b10;
        len_we = 1'b1;
        len_data = 5'd3;
        wr(4'd0, 8'h11);
        wr(4'd1, 8'h22);
        wr(4'd2, 8'h33);
        pulse_commit();
        wait_step(n);
        @(negedge clk);
        @(negedge clk);
        chk_hex("scroll_r_0", 64'h112233FFFFFFFFFF);
        do_step();
        chk_hex("scroll_r_1", 64'h331122FFFFFFFFFF);
        do_step();
        chk_hex("scroll_r_2", 64'h223311FFFFFFFFFF);
        // blink
        modes = 2'b11;
        do_step();
        chk_hex("blink_off", ALL_FF);
        do_step();
        chk_hex("blink_on", 64'h223311FFFFFFFFFF);
        // oversize length, then commit on a step edge and a second commit while busy
        len_we = 1'b1;
        len_data = 5'd20;
        wr(4'd15, 8'h6D);
        wr(4'd7, 8'h7F);
        wait_step(n);
        pulse_commit();
        chk("commit_at_step_pending", busy, 1);
        pulse_commit();
        wait_step(n);
        @(negedge clk);
        chk("second_commit_ignored", busy, 0);
        @(negedge clk);
        chk_hex("apply_len16", 64'h112233B09992827F);
        modes = 2'b10;
        do_step();
        chk_hex("clamp_wrap_r", 64'h6D112233B0999282);
        modes = 2'b01;
        do_step();
        chk_hex("clamp_wrap_l", 64'h112233B09992827F);
`ifdef HEX_DP_HEARTBEAT_EN
        h = hex0[7];
        repeat (4) @(negedge clk);
        chk("heartbeat_toggle", hex0[7], ~h);
`else
        h = hex0[7];
        chk("dp_from_buffer", h, 0);
`endif
        // asynchronous reset between clock edges
        pulse_commit();
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk_hex("async_hex", ALL_FF);
        @(negedge clk);
        rst = 1'b0;
        do_step();
        do_step();
        chk_hex("post_reset_hex", ALL_FF);
        chk("post_reset_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
